// File: rtl/logic_unit_arbiter.sv
// Round-robin share of one WIDTH-bit bitwise logic unit (XOR/AND/OR/NOR) between two requesters.
// Optional macro LU_ARB_ZERO_FLAG_EN adds a registered rsp_zero flag captured with rsp_data.
module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data
`ifdef LU_ARB_ZERO_FLAG_EN
    ,
    output logic             rsp_zero
`endif
);

    typedef enum logic [1:0] {
        OP_XOR = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    logic             last_grant;
    logic             slot_free;
    logic             grant0;
    logic             grant1;
    logic             accept;
    op_e              sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] result;

    assign slot_free = !rsp_valid || rsp_ready;

    // Under contention the requester that did not win last time is granted.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = !last_grant;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    // Readies are forced low while reset is held, since slot_free alone would be 1 then.
    assign req0_ready = rst_n && slot_free && grant0;
    assign req1_ready = rst_n && slot_free && grant1;
    assign accept     = req0_ready || req1_ready;

    assign sel_op = grant1 ? op_e'(req1_op) : op_e'(req0_op);
    assign sel_a  = grant1 ? req1_a : req0_a;
    assign sel_b  = grant1 ? req1_b : req0_b;

    always_comb begin
        result = '0;
        case (sel_op)
            OP_XOR:  result = sel_a ^ sel_b;
            OP_AND:  result = sel_a & sel_b;
            OP_OR:   result = sel_a | sel_b;
            OP_NOR:  result = ~(sel_a | sel_b);
            default: result = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            last_grant <= 1'b1;
        end else if (accept) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= grant1;
            rsp_data   <= result;
            last_grant <= grant1;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

`ifdef LU_ARB_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_zero <= 1'b0;
        end else if (accept) begin
            rsp_zero <= (result == '0);
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the arbiter and result register.
module tb_logic_unit_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0;
    logic             req0_ready;
    logic [1:0]       req0_op = 2'b00;
    logic [WIDTH-1:0] req0_a = '0;
    logic [WIDTH-1:0] req0_b = '0;
    logic             req1_valid = 1'b0;
    logic             req1_ready;
    logic [1:0]       req1_op = 2'b00;
    logic [WIDTH-1:0] req1_a = '0;
    logic [WIDTH-1:0] req1_b = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
`ifdef LU_ARB_ZERO_FLAG_EN
    logic             rsp_zero;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: held result and who won the last accepted request.
    logic             m_valid;
    logic             m_id;
    logic [WIDTH-1:0] m_data;
    logic             m_zero;
    int               m_last;

    logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
`ifdef LU_ARB_ZERO_FLAG_EN
        ,
        .rsp_zero   (rsp_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] lu(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
        case (op)
            2'd0:    return a ^ b;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return ~(a | b);
        endcase
    endfunction

    // Which requester the rules pick this cycle: -1 when nobody asks.
    function automatic int winner();
        if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_id    = 1'b0;
        m_data  = '0;
        m_zero  = 1'b0;
        m_last  = 1;
    endtask

    task automatic check_rsp(input string tag);
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(m_valid));
        check({tag, ".rsp_id"}, 32'(rsp_id), 32'(m_id));
        check({tag, ".rsp_data"}, rsp_data, m_data);
`ifdef LU_ARB_ZERO_FLAG_EN
        check({tag, ".rsp_zero"}, 32'(rsp_zero), 32'(m_zero));
`endif
    endtask

    // One clock: check readies and held result mid-cycle, predict, then advance past the edge.
    task automatic cycle(input string tag);
        int               w;
        logic             free;
        logic             nv;
        logic             nid;
        logic [WIDTH-1:0] nd;
        logic             nz;
        int               nlast;
        @(negedge clk);
        free = !m_valid || rsp_ready;
        w    = winner();
        check({tag, ".req0_ready"}, 32'(req0_ready), 32'(free && w == 0));
        check({tag, ".req1_ready"}, 32'(req1_ready), 32'(free && w == 1));
        check_rsp(tag);
        nv = m_valid; nid = m_id; nd = m_data; nz = m_zero; nlast = m_last;
        if (m_valid && rsp_ready) nv = 1'b0;
        if (free && w >= 0) begin
            nv    = 1'b1;
            nid   = (w == 1);
            nd    = (w == 0) ? lu(req0_op, req0_a, req0_b) : lu(req1_op, req1_a, req1_b);
            nz    = (nd == '0);
            nlast = w;
        end
        @(posedge clk);
        #1;
        m_valid = nv; m_id = nid; m_data = nd; m_zero = nz; m_last = nlast;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst.req0_ready", 32'(req0_ready), 32'(0));
        check("rst.req1_ready", 32'(req1_ready), 32'(0));
        check_rsp("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive0(input logic v, input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic drive1(input logic v, input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        model_reset();
        req0_valid = 1'b1;
        rsp_ready  = 1'b1;
        #2;
        apply_reset();

        // Single request from requester 0.
        drive0(1'b1, 2'd0, 32'hFFFF0000, 32'h0F0F0F0F);
        drive1(1'b0, 2'd0, '0, '0);
        cycle("single");
        drive0(1'b0, 2'd0, '0, '0);
        check("single.data", rsp_data, 32'hF0F00F0F);
        check("single.id", 32'(rsp_id), 32'(0));

        // Contention straight after reset: 0 first, then alternate.
        apply_reset();
        drive0(1'b1, 2'd1, 32'hFF00FF00, 32'h0FF00FF0);
        drive1(1'b1, 2'd3, 32'h0, 32'h0);
        cycle("cont0");
        check("cont0.data", rsp_data, 32'h0F000F00);
        check("cont0.id", 32'(rsp_id), 32'(0));
        cycle("cont1");
        check("cont1.data", rsp_data, 32'hFFFFFFFF);
        check("cont1.id", 32'(rsp_id), 32'(1));
        cycle("cont2");
        check("cont2.id", 32'(rsp_id), 32'(0));
        cycle("cont3");
        check("cont3.id", 32'(rsp_id), 32'(1));

        // Back-pressure then same-cycle drain and accept.
        drive0(1'b0, 2'd0, '0, '0);
        drive1(1'b1, 2'd2, 32'h1, 32'h2);
        rsp_ready = 1'b0;
        held = rsp_data;
        for (int i = 0; i < 3; i++) cycle("bp");
        check("bp.data_stable", rsp_data, held);
        rsp_ready = 1'b1;
        cycle("bp_release");
        check("bp_release.valid", 32'(rsp_valid), 32'(1));
        check("bp_release.data", rsp_data, 32'h3);

        // Drain with no requests; fairness pointer must be left at 1.
        drive1(1'b0, 2'd0, '0, '0);
        cycle("drain");
        check("drain.valid", 32'(rsp_valid), 32'(0));
        drive0(1'b1, 2'd0, 32'h5, 32'h6);
        drive1(1'b1, 2'd0, 32'h7, 32'h8);
        cycle("after_drain");
        check("after_drain.id", 32'(rsp_id), 32'(0));

        // Reset while a result is held and stalled.
        drive0(1'b0, 2'd0, '0, '0);
        drive1(1'b0, 2'd0, '0, '0);
        rsp_ready = 1'b0;
        apply_reset();
        rsp_ready = 1'b1;
        drive1(1'b1, 2'd0, 32'hA5A5A5A5, 32'h0000FFFF);
        cycle("post_rst1");
        check("post_rst1.id", 32'(rsp_id), 32'(1));
        check("post_rst1.data", rsp_data, 32'hA5A55A5A);
        drive0(1'b1, 2'd2, 32'h10, 32'h01);
        cycle("post_rst_cont");
        check("post_rst_cont.id", 32'(rsp_id), 32'(0));

`ifdef LU_ARB_ZERO_FLAG_EN
        drive1(1'b0, 2'd0, '0, '0);
        drive0(1'b1, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF);
        cycle("zero1");
        check("zero1.data", rsp_data, 32'h0);
        check("zero1.flag", 32'(rsp_zero), 32'(1));
        drive0(1'b1, 2'd0, 32'h1, 32'h0);
        cycle("zero0");
        check("zero0.flag", 32'(rsp_zero), 32'(0));
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive0(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom(), $urandom());
            drive1(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom(), $urandom());
            if ($urandom_range(0, 15) == 0) begin
                req0_a = '0; req0_b = '0;
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
